board_generator: RTL

- Produces the hidden tile pattern ("board") for a Memory Matrix round, shows it for a fixed time, then hides it and holds it for the guess-checking logic.
- Sits upstream of the guess checker: its `board` output is the `board` input the checker ANDs guesses against.
- `board_ready` tells the guess and round control that guessing may begin.

---
 rtl/game_pkg.sv | 29 ++
 rtl/lfsr8.sv | 19 +
 rtl/board_generator.sv | 97 +++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared Memory Matrix definitions: board geometry, LFSR constants,
// generator state encoding and the target clamp helper.
package game_pkg;

  localparam int BOARD_W             = 8;
  localparam int IDX_W               = $clog2(BOARD_W);
  localparam int PLACE_W             = IDX_W + 1;
  localparam int DEFAULT_SHOW_CYCLES = 50_000_000;

  // Nonzero seed; the LFSR never leaves the nonzero cycle.
  localparam logic [7:0] DEFAULT_LFSR_SEED = 8'hB5;

  // x^8 + x^6 + x^5 + x^4 + 1, shifting left: feedback from bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    SHOW = 2'd2,
    DONE = 2'd3
  } gen_state_t;

  // Requests above the board size light every tile.
  function automatic logic [PLACE_W-1:0] clamp_target(input logic [3:0] tile_count);
    if (int'(tile_count) > BOARD_W) return PLACE_W'(BOARD_W);
    else return PLACE_W'(tile_count);
  endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, reseeded by reset so pattern
// sequences are reproducible for a given start timing.
module lfsr8
  import game_pkg::*;
#(
  parameter logic [7:0] SEED = DEFAULT_LFSR_SEED
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] state
);

  // Shift left every cycle, feeding back the XOR of the tapped bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SEED;
    else        state <= {state[6:0], ^(state & LFSR_TAPS)};
  end

endmodule

// File: rtl/board_generator.sv
// Memory Matrix board generator: places the requested number of tiles at
// pseudo-random positions, shows the pattern for SHOW_CYCLES, then holds it
// for the guess checker.
//
// state | meaning
// IDLE  | after reset, waiting for start, all outputs low
// GEN   | placing one tile per cycle at lfsr-chosen free positions
// SHOW  | pattern displayed, counting down SHOW_CYCLES
// DONE  | pattern hidden and held, board_ready high, start begins a new round
module board_generator
  import game_pkg::*;
#(
  parameter int         SHOW_CYCLES = DEFAULT_SHOW_CYCLES,
  parameter logic [7:0] LFSR_SEED   = DEFAULT_LFSR_SEED
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         tile_count,
  output logic [BOARD_W-1:0] board,
  output logic               show,
  output logic               board_ready,
  output logic               busy
);

  localparam int              SC_W      = $clog2(SHOW_CYCLES) + 1;
  localparam logic [SC_W-1:0] SHOW_LAST = SC_W'(SHOW_CYCLES - 1);

  gen_state_t         state;
  logic [7:0]         lfsr_state;
  logic [IDX_W-1:0]   idx;
  logic [PLACE_W-1:0] target;
  logic [PLACE_W-1:0] placed;
  logic [SC_W-1:0]    show_cnt;
  logic               unused_lfsr_bits;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr_state)
  );

  // Only the low bits pick a tile; the rest only feed the shift register.
  assign idx              = lfsr_state[IDX_W-1:0];
  assign unused_lfsr_bits = ^lfsr_state[7:IDX_W];

  // Round sequencing with registered outputs; the show timer is a down-counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      board       <= '0;
      show        <= 1'b0;
      board_ready <= 1'b0;
      busy        <= 1'b0;
      target      <= '0;
      placed      <= '0;
      show_cnt    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= GEN;
            target      <= clamp_target(tile_count);
            board       <= '0;
            placed      <= '0;
            board_ready <= 1'b0;
            busy        <= 1'b1;
            show        <= 1'b0;
          end
        end
        GEN: begin
          // Completion is tested before placing, so a zero target leaves at once.
          if (placed == target) begin
            state    <= SHOW;
            show     <= 1'b1;
            show_cnt <= SHOW_LAST;
          end else if (!board[idx]) begin
            board[idx] <= 1'b1;
            placed     <= placed + PLACE_W'(1);
          end
        end
        SHOW: begin
          if (show_cnt == '0) begin
            state       <= DONE;
            show        <= 1'b0;
            busy        <= 1'b0;
            board_ready <= 1'b1;
          end else begin
            show_cnt <= show_cnt - SC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
